// File: rtl/fifo_pkg.sv
// Shared types and size helpers for the single-clock TX FIFO.
// Build option FIFO_FWFT_EN is consumed by fifo_sync_tx_v2.
package fifo_pkg;

    typedef struct packed {
        logic rempty;
        logic wfull;
        logic r_almost_empty;
        logic w_almost_full;
    } fifo_status_t;

    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

    function automatic int unsigned fifo_cnt_w(input int unsigned addrsize);
        return addrsize + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_mem_sync.sv
// DEPTH x DATASIZE register array: synchronous write, asynchronous read.
module fifo_mem_sync
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDRSIZE);

    logic [DATASIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_tx_v2.sv
// Single-clock TX FIFO with thresholds, occupancy count, flush and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through read data; default is registered read.
module fifo_sync_tx_v2
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DATASIZE-1:0] wdata_i,
    input  logic                winc_i,
    input  logic                rinc_i,
    input  logic                flush_i,
    input  logic                clr_err_i,
    input  logic [ADDRSIZE:0]   afull_thresh_i,
    input  logic [ADDRSIZE:0]   aempty_thresh_i,
    output logic [DATASIZE-1:0] rdata_o,
    output logic                rempty_o,
    output logic                wfull_o,
    output logic                r_almost_empty_o,
    output logic                w_almost_full_o,
    output logic [ADDRSIZE:0]   count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int unsigned CW = fifo_cnt_w(ADDRSIZE);
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {ADDRSIZE{1'b0}}};

    logic [ADDRSIZE-1:0] wptr;
    logic [ADDRSIZE-1:0] rptr;
    logic [CW-1:0]       count;
    fifo_status_t        status;
    logic                wacc;
    logic                racc;
    logic                mem_we;
    logic [DATASIZE-1:0] mem_rdata;

    always_comb begin
        status                = '0;
        status.rempty         = (count == '0);
        status.wfull          = (count == FULL_CNT);
        status.r_almost_empty = (count <= aempty_thresh_i);
        status.w_almost_full  = (count >= afull_thresh_i);
    end

    assign wacc   = winc_i && !status.wfull;
    assign racc   = rinc_i && !status.rempty;
    assign mem_we = wacc && !flush_i && !rst_i;

    fifo_mem_sync #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_mem (
        .clk   (clk_i),
        .we    (mem_we),
        .waddr (wptr),
        .wdata (wdata_i),
        .raddr (rptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wacc) wptr <= wptr + 1'b1;
            if (racc) rptr <= rptr + 1'b1;
            case ({wacc, racc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set beats clear when both happen in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (winc_i && status.wfull) overflow_o <= 1'b1;
            else if (clr_err_i)         overflow_o <= 1'b0;
            if (rinc_i && status.rempty) underflow_o <= 1'b1;
            else if (clr_err_i)          underflow_o <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rdata_o = mem_rdata;
`else
    always_ff @(posedge clk_i) begin
        if (rst_i)                rdata_o <= '0;
        else if (racc && !flush_i) rdata_o <= mem_rdata;
    end
`endif

    assign rempty_o         = status.rempty;
    assign wfull_o          = status.wfull;
    assign r_almost_empty_o = status.r_almost_empty;
    assign w_almost_full_o  = status.w_almost_full;
    assign count_o          = count;

endmodule

// File: tb/tb_fifo_sync_tx_v2.sv
// Scoreboard bench for fifo_sync_tx_v2 (DATASIZE=8, ADDRSIZE=4, afull=14, aempty=2).
// Honours FIFO_FWFT_EN: read data is sampled before the pop in that build.
module tb_fifo_sync_tx_v2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] wdata_i = '0;
    logic       winc_i = 1'b0;
    logic       rinc_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       clr_err_i = 1'b0;
    logic [4:0] afull_thresh_i = 5'd14;
    logic [4:0] aempty_thresh_i = 5'd2;
    logic [7:0] rdata_o;
    logic       rempty_o;
    logic       wfull_o;
    logic       r_almost_empty_o;
    logic       w_almost_full_o;
    logic [4:0] count_o;
    logic       overflow_o;
    logic       underflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] popped = '0;
    logic       did_pop = 1'b0;

    fifo_sync_tx_v2 #(
        .DATASIZE (8),
        .ADDRSIZE (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .wdata_i          (wdata_i),
        .winc_i           (winc_i),
        .rinc_i           (rinc_i),
        .flush_i          (flush_i),
        .clr_err_i        (clr_err_i),
        .afull_thresh_i   (afull_thresh_i),
        .aempty_thresh_i  (aempty_thresh_i),
        .rdata_o          (rdata_o),
        .rempty_o         (rempty_o),
        .wfull_o          (wfull_o),
        .r_almost_empty_o (r_almost_empty_o),
        .w_almost_full_o  (w_almost_full_o),
        .count_o          (count_o),
        .overflow_o       (overflow_o),
        .underflow_o      (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; the queue model is updated from pre-edge occupancy.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic fl, input logic ce);
        logic full_now, empty_now, wa, ra;
        full_now  = (m_q.size() == 16);
        empty_now = (m_q.size() == 0);
        wa = w && !full_now;
        ra = r && !empty_now;
        winc_i = w; wdata_i = d; rinc_i = r; flush_i = fl; clr_err_i = ce;
        @(posedge clk_i); #1;
        winc_i = 1'b0; rinc_i = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0;
        did_pop = 1'b0;
        if (w && full_now) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
        if (r && empty_now) m_unf = 1'b1; else if (ce) m_unf = 1'b0;
        if (fl) m_q.delete();
        else begin
            if (ra) begin popped = m_q.pop_front(); did_pop = 1'b1; end
            if (wa) m_q.push_back(d);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count_o !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        n_checks++; if (rempty_o !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b expected 1", rempty_o); end
        n_checks++; if (wfull_o !== 1'b0) begin n_fail++; $display("FAIL reset_wfull: got %b expected 0", wfull_o); end
        n_checks++; if (r_almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b expected 1", r_almost_empty_o); end
        n_checks++; if (w_almost_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_afull: got %b expected 0", w_almost_full_o); end
        n_checks++; if ({overflow_o, underflow_o} !== 2'b00) begin n_fail++; $display("FAIL reset_errs: got %b%b expected 00", overflow_o, underflow_o); end
`ifndef FIFO_FWFT_EN
        n_checks++; if (rdata_o !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata_o); end
`endif
    endtask

    task automatic test_fill_drain();
        logic [7:0] seen;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            n_checks++; if (count_o !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count_o, i + 1); end
            n_checks++; if (w_almost_full_o !== (i + 1 >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, w_almost_full_o, (i + 1 >= 14)); end
            n_checks++; if (wfull_o !== (i == 15)) begin n_fail++; $display("FAIL fill_wfull[%0d]: got %b expected %b", i, wfull_o, (i == 15)); end
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", overflow_o); end
        n_checks++; if (count_o !== 5'd16) begin n_fail++; $display("FAIL overflow_count: got %0d expected 16", count_o); end
        for (int i = 0; i < 16; i++) begin
            seen = rdata_o;
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
            seen = rdata_o;
`endif
            n_checks++; if (!did_pop || seen !== popped || popped !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, seen, 8'(i)); end
        end
        n_checks++; if (rempty_o !== 1'b1) begin n_fail++; $display("FAIL drain_rempty: got %b expected 1", rempty_o); end
        n_checks++; if (underflow_o !== 1'b0) begin n_fail++; $display("FAIL drain_no_unf: got %b expected 0", underflow_o); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++; if (underflow_o !== m_unf) begin n_fail++; $display("FAIL underflow_set: got %b expected %b", underflow_o, m_unf); end
        n_checks++; if (count_o !== 5'd0) begin n_fail++; $display("FAIL underflow_count: got %0d expected 0", count_o); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] seen;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        n_checks++; if (count_o !== 5'd5) begin n_fail++; $display("FAIL simul_count5: got %0d expected 5", count_o); end
        for (int i = 0; i < 5; i++) begin
            seen = rdata_o;
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
            seen = rdata_o;
`endif
            n_checks++; if (seen !== popped || popped !== 8'(8'h51 + i)) begin n_fail++; $display("FAIL simul_order[%0d]: got %h expected %h", i, seen, 8'(8'h51 + i)); end
        end
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        n_checks++; if (count_o !== 5'd15) begin n_fail++; $display("FAIL full_both_count: got %0d expected 15", count_o); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL full_both_ovf: got %b expected 1", overflow_o); end
        do_reset();
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        n_checks++; if (count_o !== 5'd1) begin n_fail++; $display("FAIL empty_both_count: got %0d expected 1", count_o); end
        n_checks++; if (underflow_o !== 1'b1) begin n_fail++; $display("FAIL empty_both_unf: got %b expected 1", underflow_o); end
        seen = rdata_o;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
        seen = rdata_o;
`endif
        n_checks++; if (seen !== 8'h77 || popped !== 8'h77) begin n_fail++; $display("FAIL empty_both_data: got %h expected 77", seen); end
    endtask

    task automatic test_wrap();
        logic [7:0] seen;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            seen = rdata_o;
            step(1'b1, 8'(8'hC3 + k), 1'b1, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
            seen = rdata_o;
`endif
            n_checks++; if (seen !== popped || popped !== 8'(8'hC0 + k)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, seen, 8'(8'hC0 + k)); end
            n_checks++; if (count_o !== 5'd3) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected 3", k, count_o); end
        end
    endtask

    task automatic test_flush();
        logic [7:0] seen;
        logic [7:0] held;
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++; if (count_o !== 5'd9) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 9", count_o); end
        held = rdata_o;
        step(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (count_o !== 5'd0 || rempty_o !== 1'b1) begin n_fail++; $display("FAIL flush_clear: got count %0d empty %b expected 0 1", count_o, rempty_o); end
        n_checks++; if ({overflow_o, underflow_o} !== {m_ovf, m_unf}) begin n_fail++; $display("FAIL flush_errs_kept: got %b%b expected %b%b", overflow_o, underflow_o, m_ovf, m_unf); end
`ifndef FIFO_FWFT_EN
        n_checks++; if (rdata_o !== held) begin n_fail++; $display("FAIL flush_rdata_held: got %h expected %h", rdata_o, held); end
`endif
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++; if ({overflow_o, underflow_o} !== 2'b00) begin n_fail++; $display("FAIL clr_err: got %b%b expected 00", overflow_o, underflow_o); end
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        seen = rdata_o;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
        seen = rdata_o;
`endif
        n_checks++; if (seen !== 8'h3C || popped !== 8'h3C) begin n_fail++; $display("FAIL flush_discard: got %h expected 3c", seen); end
    endtask

    task automatic test_thresholds();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        n_checks++; if (r_almost_empty_o !== 1'b0) begin n_fail++; $display("FAIL aempty_at3: got %b expected 0", r_almost_empty_o); end
        aempty_thresh_i = 5'd3; #1;
        n_checks++; if (r_almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL aempty_eq3: got %b expected 1", r_almost_empty_o); end
        aempty_thresh_i = 5'd20;
        afull_thresh_i  = 5'd20;
        for (int i = 3; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        n_checks++; if (r_almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL aempty_above_depth: got %b expected 1", r_almost_empty_o); end
        n_checks++; if (w_almost_full_o !== 1'b0) begin n_fail++; $display("FAIL afull_above_depth: got %b expected 0", w_almost_full_o); end
        afull_thresh_i = 5'd16; #1;
        n_checks++; if (w_almost_full_o !== 1'b1) begin n_fail++; $display("FAIL afull_eq16: got %b expected 1", w_almost_full_o); end
        afull_thresh_i  = 5'd14;
        aempty_thresh_i = 5'd2;
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft();
        do_reset();
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        n_checks++; if (rempty_o !== 1'b0) begin n_fail++; $display("FAIL fwft_rempty: got %b expected 0", rempty_o); end
        n_checks++; if (rdata_o !== 8'hA5) begin n_fail++; $display("FAIL fwft_rdata: got %h expected a5", rdata_o); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_checks++; if (rempty_o !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_empty: got %b expected 1", rempty_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_wrap();
        test_flush();
        test_thresholds();
`ifdef FIFO_FWFT_EN
        test_fwft();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
